blink_rk_sequencer: RTL and testbench

- Round-key sequencer for an iterative Blink-128 core; serves both directions of the cipher.
- Accepts one block's key material (K0, 8 x 128-bit keys) and tweak T (256-bit) through a load handshake.
- Streams 16 per-round keys (round key XOR tweak half) to the core through a valid/ready handshake.
- Order is forward (round 0..15) when enc=1 and reversed (round 15..0) when enc=0, so the same datapath decrypts.

---
 rtl/blink_pkg.sv | 25 ++
 rtl/blink_rk_sequencer.sv | 87 ++++++++
 tb/tb_blink_rk_sequencer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/blink_pkg.sv
// Shared widths, state encoding and round-key selection for the Blink-128 key sequencer.
package blink_pkg;
    localparam int N         = 128;
    localparam int ROUNDS    = 16;
    localparam int NKEYS     = ROUNDS / 2;
    localparam int TWEAK_LEN = 2 * N;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Each stored key covers two rounds; the round LSB picks the tweak half.
    function automatic logic [N-1:0] rk_sel(
        input logic [N*NKEYS-1:0]   keys,
        input logic [TWEAK_LEN-1:0] tw,
        input logic [3:0]           r
    );
        int ki;
        int ti;
        ki = int'(r[3:1]);
        ti = int'(r[0]);
        return keys[ki*N +: N] ^ tw[ti*N +: N];
    endfunction
endpackage

// File: rtl/blink_rk_sequencer.sv
// Round-key sequencer: latches K0/T/enc on load, streams 16 round keys forward or reversed.
// Outputs registered; first key one cycle after load; holds while rk_valid && !rk_ready.
module blink_rk_sequencer
    import blink_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic                 enc,
    input  logic [N*NKEYS-1:0]   K0,
    input  logic [TWEAK_LEN-1:0] T,
    output logic                 rk_valid,
    input  logic                 rk_ready,
    output logic [N-1:0]         rk_data,
    output logic [3:0]           rk_round,
    output logic                 rk_last,
    output logic                 busy
);
    state_t                 state_q;
    logic                   enc_q;
    logic [N*NKEYS-1:0]     key_q;
    logic [TWEAK_LEN-1:0]   tw_q;
    logic [3:0]             round_q;
    logic [3:0]             round_d;
    logic                   last_d;
    logic                   valid_q;
    logic                   last_q;
    logic [N-1:0]           data_q;
    logic [3:0]             start_round;
    logic                   accept;

    assign accept      = (state_q == RUN) && valid_q && rk_ready;
    assign round_d     = enc_q ? (round_q + 4'd1) : (round_q - 4'd1);
    assign last_d      = enc_q ? (round_d == 4'd15) : (round_d == 4'd0);
    assign start_round = enc ? 4'd0 : 4'd15;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            enc_q   <= 1'b0;
            key_q   <= '0;
            tw_q    <= '0;
            round_q <= 4'd0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_valid) begin
                        key_q   <= K0;
                        tw_q    <= T;
                        enc_q   <= enc;
                        state_q <= RUN;
                        valid_q <= 1'b1;
                        round_q <= start_round;
                        // First key comes straight from the inputs so it is ready next cycle.
                        data_q  <= rk_sel(K0, T, start_round);
                        last_q  <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (last_q) begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                            data_q  <= '0;
                        end else begin
                            round_q <= round_d;
                            data_q  <= rk_sel(key_q, tw_q, round_d);
                            last_q  <= last_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q == RUN);
    assign rk_valid   = valid_q;
    assign rk_data    = data_q;
    assign rk_round   = round_q;
    assign rk_last    = last_q;
endmodule

// File: tb/tb_blink_rk_sequencer.sv
// Bench for blink_rk_sequencer: directed scenarios plus randomized blocks against a key-schedule model.
module tb_blink_rk_sequencer;
    import blink_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 load_valid;
    logic                 load_ready;
    logic                 enc;
    logic [N*NKEYS-1:0]   K0;
    logic [TWEAK_LEN-1:0] T;
    logic                 rk_valid;
    logic                 rk_ready;
    logic [N-1:0]         rk_data;
    logic [3:0]           rk_round;
    logic                 rk_last;
    logic                 busy;

    int tests = 0;
    int fails = 0;

    logic [N-1:0] dkeys [8];
    logic [N-1:0] dtw   [2];
    logic [N-1:0] mkeys [8];
    logic [N-1:0] mtw   [2];

    always #5 clk = ~clk;

    blink_rk_sequencer dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_ready(load_ready),
        .enc(enc), .K0(K0), .T(T),
        .rk_valid(rk_valid), .rk_ready(rk_ready),
        .rk_data(rk_data), .rk_round(rk_round), .rk_last(rk_last),
        .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < 8; i++) K0[i*N +: N] = dkeys[i];
        T[0 +: N] = dtw[0];
        T[N +: N] = dtw[1];
    endtask

    task automatic plan_keys();
        for (int i = 0; i < 8; i++) dkeys[i] = {16{8'(i+1)}};
        dtw[0] = '0;
        dtw[1] = '1;
        drive_inputs();
    endtask

    task automatic random_keys();
        for (int i = 0; i < 8; i++)
            dkeys[i] = {$urandom, $urandom, $urandom, $urandom};
        dtw[0] = {$urandom, $urandom, $urandom, $urandom};
        dtw[1] = {$urandom, $urandom, $urandom, $urandom};
        drive_inputs();
    endtask

    task automatic latch_model();
        for (int i = 0; i < 8; i++) mkeys[i] = dkeys[i];
        mtw[0] = dtw[0];
        mtw[1] = dtw[1];
    endtask

    function automatic logic [N-1:0] ref_rk(input int r);
        return mkeys[r / 2] ^ mtw[r % 2];
    endfunction

    task automatic apply_reset();
        rst = 1'b0; load_valid = 1'b0; rk_ready = 1'b1; enc = 1'b1;
        step();
        rst = 1'b1;
    endtask

    task automatic do_load(input bit e);
        enc = e;
        load_valid = 1'b1;
        tests++;
        if (load_ready !== 1'b1) begin
            fails++; $display("FAIL load_ready_before_load got %b want 1", load_ready);
        end
        step();
        load_valid = 1'b0;
        latch_model();
        tests++;
        if (rk_valid !== 1'b1 || busy !== 1'b1) begin
            fails++; $display("FAIL load_latency rk_valid=%b busy=%b want 1/1", rk_valid, busy);
        end
    endtask

    task automatic check_idle(input string nm);
        tests++;
        if (rk_valid !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1 || rk_data !== '0) begin
            fails++;
            $display("FAIL %s rk_valid=%b busy=%b load_ready=%b rk_data=%h want 0/0/1/0",
                     nm, rk_valid, busy, load_ready, rk_data);
        end
    endtask

    // Assumes the first key of a block is currently presented.
    task automatic run_stream(input bit e, input int stall_r, input int stall_n,
                              input int ign_lo, input int ign_hi, input string nm);
        for (int i = 0; i < 16; i++) begin
            int r;
            r = e ? i : 15 - i;
            if (i == ign_lo) begin
                load_valid = 1'b1;
                enc = ~e;
                K0 = {8{$urandom, $urandom, $urandom, $urandom}};
            end
            if (i == ign_hi) begin
                load_valid = 1'b0;
                drive_inputs();
            end
            if (i >= ign_lo && i < ign_hi) begin
                tests++;
                if (load_ready !== 1'b0) begin
                    fails++; $display("FAIL %s load_ready_in_run got %b want 0", nm, load_ready);
                end
            end
            if (r == stall_r) begin
                rk_ready = 1'b0;
                for (int c = 0; c < stall_n; c++) begin
                    tests++;
                    if (rk_valid !== 1'b1 || rk_round !== 4'(r) || rk_data !== ref_rk(r)) begin
                        fails++;
                        $display("FAIL %s stall_hold c=%0d round=%0d data=%h want round=%0d data=%h",
                                 nm, c, rk_round, rk_data, r, ref_rk(r));
                    end
                    step();
                end
                rk_ready = 1'b1;
            end
            tests++;
            if (rk_valid !== 1'b1 || rk_round !== 4'(r) || rk_data !== ref_rk(r) ||
                rk_last !== (i == 15) || busy !== 1'b1) begin
                fails++;
                $display("FAIL %s key i=%0d valid=%b round=%0d last=%b data=%h want round=%0d last=%b data=%h",
                         nm, i, rk_valid, rk_round, rk_last, rk_data, r, (i == 15), ref_rk(r));
            end
            step();
        end
        check_idle({nm, "_end"});
    endtask

    task automatic test_reset();
        rst = 1'b0; load_valid = 1'b1; rk_ready = 1'b1; enc = 1'b1;
        plan_keys();
        step();
        step();
        tests++;
        if (rk_valid !== 1'b0 || load_ready !== 1'b1 || busy !== 1'b0 ||
            rk_data !== '0 || rk_round !== 4'd0 || rk_last !== 1'b0) begin
            fails++;
            $display("FAIL reset_state valid=%b ready=%b busy=%b data=%h round=%0d last=%b",
                     rk_valid, load_ready, busy, rk_data, rk_round, rk_last);
        end
        rst = 1'b1; load_valid = 1'b0;
    endtask

    task automatic test_encrypt();
        apply_reset(); plan_keys();
        do_load(1'b1);
        run_stream(1'b1, -1, 0, -1, -1, "enc");
        tests++;
        if (rk_round !== 4'd15 || rk_last !== 1'b1) begin
            fails++; $display("FAIL enc_round_kept round=%0d last=%b want 15/1", rk_round, rk_last);
        end
    endtask

    task automatic test_decrypt();
        apply_reset(); plan_keys();
        do_load(1'b0);
        run_stream(1'b0, -1, 0, -1, -1, "dec");
    endtask

    task automatic test_backpressure();
        apply_reset(); plan_keys();
        do_load(1'b1);
        run_stream(1'b1, 5, 3, -1, -1, "bp");
    endtask

    task automatic test_reset_mid_run();
        apply_reset(); plan_keys();
        do_load(1'b1);
        for (int r = 0; r < 9; r++) step();
        tests++;
        if (rk_round !== 4'd9 || rk_data !== ref_rk(9)) begin
            fails++; $display("FAIL midrun_pos round=%0d data=%h want 9 %h", rk_round, rk_data, ref_rk(9));
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        check_idle("midrun_reset");
        do_load(1'b1);
        run_stream(1'b1, -1, 0, -1, -1, "midrun_restart");
    endtask

    task automatic test_ignored_load();
        apply_reset(); plan_keys();
        do_load(1'b1);
        run_stream(1'b1, -1, 0, 4, 8, "ignload");
    endtask

    task automatic test_back_to_back();
        int found;
        bit gap;
        apply_reset(); plan_keys();
        enc = 1'b1; load_valid = 1'b1; rk_ready = 1'b1;
        step();
        latch_model();
        random_keys();
        found = -1; gap = 1'b0;
        for (int c = 1; c <= 40 && found < 0; c++) begin
            step();
            if (c < 16) begin
                tests++;
                if (rk_round !== 4'(c) || rk_data !== ref_rk(c)) begin
                    fails++;
                    $display("FAIL b2b_first c=%0d round=%0d data=%h want %0d %h", c, rk_round, rk_data, c, ref_rk(c));
                end
            end
            if (!rk_valid) gap = 1'b1;
            if (rk_valid && rk_round == 4'd0 && gap) found = c;
        end
        load_valid = 1'b0;
        tests++;
        if (found != 17) begin
            fails++; $display("FAIL b2b_period got %0d want 17", found);
        end
        if (found > 0) begin
            latch_model();
            run_stream(1'b1, -1, 0, -1, -1, "b2b_second");
        end
    endtask

    task automatic test_random();
        for (int b = 0; b < 6; b++) begin
            bit e;
            int idx;
            apply_reset();
            random_keys();
            e = 1'($urandom_range(0, 1));
            do_load(e);
            idx = 0;
            for (int c = 0; c < 200 && idx < 16; c++) begin
                int r;
                bit rdy;
                r = e ? idx : 15 - idx;
                rdy = 1'($urandom_range(0, 1));
                rk_ready = rdy;
                tests++;
                if (rk_valid !== 1'b1 || rk_round !== 4'(r) || rk_data !== ref_rk(r) ||
                    rk_last !== (idx == 15)) begin
                    fails++;
                    $display("FAIL rand b=%0d idx=%0d round=%0d last=%b data=%h want %0d %b %h",
                             b, idx, rk_round, rk_last, rk_data, r, (idx == 15), ref_rk(r));
                end
                step();
                if (rdy) idx++;
            end
            rk_ready = 1'b1;
            tests++;
            if (idx != 16) begin
                fails++; $display("FAIL rand_budget b=%0d accepted %0d want 16", b, idx);
            end
            check_idle("rand_end");
        end
    endtask

    initial begin
        rst = 1'b0; load_valid = 1'b0; rk_ready = 1'b1; enc = 1'b1; K0 = '0; T = '0;
        test_reset();
        test_encrypt();
        test_decrypt();
        test_backpressure();
        test_reset_mid_run();
        test_ignored_load();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
